// File: rtl/general_defs.sv
// Shared type definitions for the fetch front end.
//   HALF_WORD          : one 16-bit Thumb instruction
//   WORD               : 32-bit byte address / data word
//   stall_pipeline_sig : pipeline stall request
//   fetch_state_t      : fetch_unit control states
package general_defs;

  typedef logic [15:0] HALF_WORD;
  typedef logic [31:0] WORD;
  typedef logic        stall_pipeline_sig;

  // LOAD : instruction RAM is being filled from the load port
  // PRIME: one dead cycle that presents RESET_PC before fetching starts
  // RUN  : program counter sequencing
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Program-counter and fetch-control stage feeding the instruction memory.
// After reset it loads halfwords into instruction RAM at sequential byte
// addresses, then sequences the PC (stall hold, taken-branch redirect).
//
// Parameters
//   MEM_BYTES : instruction RAM size in bytes (power of two)
//   RESET_PC  : byte address of the first fetched instruction (even)
// Ports
//   clk_i, reset_i             : clock, asynchronous active-high reset
//   program_load_i             : stay in / return to the load phase
//   load_valid_i, load_data_i  : halfword to write during load
//   stall_pipeline_i           : hold the PC
//   branch_taken_i, branch_target_i : redirect request and byte target
//   program_mem_write_en_o     : RAM write strobe
//   instruction_o              : RAM write data
//   instruction_addr_o         : RAM byte address (write or fetch)
//   is_valid_o                 : issued fetch is a real instruction
//   load_overflow_o            : sticky, a write was attempted past capacity
//   running_o                  : fetching in RUN
module fetch_unit
  import general_defs::*;
#(
  parameter int MEM_BYTES = 512,
  parameter int RESET_PC  = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        program_load_i,
  input  logic        load_valid_i,
  input  logic [15:0] load_data_i,
  input  logic        stall_pipeline_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        program_mem_write_en_o,
  output logic [15:0] instruction_o,
  output logic [31:0] instruction_addr_o,
  output logic        is_valid_o,
  output logic        load_overflow_o,
  output logic        running_o
);

  localparam int AW = $clog2(MEM_BYTES);

  // load_ptr needs one extra bit so it can reach MEM_BYTES ("RAM full").
  localparam logic [AW:0]   LOAD_FULL  = (AW+1)'(MEM_BYTES);
  localparam logic [AW:0]   LOAD_STEP  = (AW+1)'(2);
  localparam logic [AW-1:0] PC_STEP    = AW'(2);
  localparam logic [AW-1:0] RESET_PC_A = AW'(RESET_PC);

  fetch_state_t  state_q, state_d;
  logic [AW:0]   load_ptr_q, load_ptr_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          we_q, we_d;
  HALF_WORD      data_q, data_d;
  WORD           addr_q, addr_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          running_q, running_d;

  // Branch target reduced modulo RAM size with bit 0 forced to zero.
  logic [AW-1:0] target_a;
  assign target_a = {branch_target_i[AW-1:1], 1'b0};

  // Upper target bits and bit 0 are deliberately discarded.
  logic unused_target_bits;
  assign unused_target_bits = ^{branch_target_i[31:AW], branch_target_i[0]};

  always_comb begin
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    pc_d       = pc_q;
    we_d       = 1'b0;
    data_d     = data_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    running_d  = running_q;

    case (state_q)
      LOAD: begin
        valid_d   = 1'b0;
        running_d = 1'b0;
        // A valid arriving with program_load_i low is still written.
        if (load_valid_i) begin
          if (load_ptr_q == LOAD_FULL) begin
            ovf_d = 1'b1;
          end else begin
            we_d       = 1'b1;
            data_d     = load_data_i;
            addr_d     = WORD'(load_ptr_q);
            load_ptr_d = load_ptr_q + LOAD_STEP;
          end
        end
        if (!program_load_i) begin
          state_d = PRIME;
        end
      end

      PRIME: begin
        addr_d    = WORD'(RESET_PC_A);
        valid_d   = 1'b0;
        running_d = 1'b0;
        pc_d      = RESET_PC_A;
        state_d   = RUN;
      end

      RUN: begin
        if (program_load_i) begin
          state_d    = LOAD;
          load_ptr_d = '0;
          valid_d    = 1'b0;
          running_d  = 1'b0;
        end else begin
          running_d = 1'b1;
          if (branch_taken_i) begin
            // Bubble on the target, the instruction after it comes next.
            addr_d  = WORD'(target_a);
            valid_d = 1'b0;
            pc_d    = target_a + PC_STEP;
          end else if (!stall_pipeline_i) begin
            addr_d  = WORD'(pc_q);
            valid_d = 1'b1;
            pc_d    = pc_q + PC_STEP;
          end
          // Stall without branch: address, validity and PC all hold.
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= LOAD;
      load_ptr_q <= '0;
      pc_q       <= RESET_PC_A;
      we_q       <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
      pc_q       <= pc_d;
      we_q       <= we_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      running_q  <= running_d;
    end
  end

  assign program_mem_write_en_o = we_q;
  assign instruction_o          = data_q;
  assign instruction_addr_o     = addr_q;
  assign is_valid_o             = valid_q;
  assign load_overflow_o        = ovf_q;
  assign running_o              = running_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default-size instance and an 8-byte
// instance share stimulus so capacity and wrap-around can be exercised.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        program_load_i = 1'b1;
  logic        load_valid_i = 1'b0;
  logic [15:0] load_data_i = '0;
  logic        stall_pipeline_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;

  logic        we, valid, ovf, running;
  logic [15:0] data;
  logic [31:0] addr;
  logic        we8, valid8, ovf8, running8;
  logic [15:0] data8;
  logic [31:0] addr8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.MEM_BYTES(512), .RESET_PC(0)) dut (
    .clk_i(clk), .reset_i(reset_i), .program_load_i(program_load_i),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i),
    .stall_pipeline_i(stall_pipeline_i), .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i),
    .program_mem_write_en_o(we), .instruction_o(data),
    .instruction_addr_o(addr), .is_valid_o(valid),
    .load_overflow_o(ovf), .running_o(running)
  );

  fetch_unit #(.MEM_BYTES(8), .RESET_PC(0)) dut8 (
    .clk_i(clk), .reset_i(reset_i), .program_load_i(program_load_i),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i),
    .stall_pipeline_i(stall_pipeline_i), .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i),
    .program_mem_write_en_o(we8), .instruction_o(data8),
    .instruction_addr_o(addr8), .is_valid_o(valid8),
    .load_overflow_o(ovf8), .running_o(running8)
  );

  // Advance one cycle and observe shortly after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t we=%b addr=%h data=%h valid=%b run=%b ovf=%b | dut8 we=%b addr=%h ovf=%b",
             $time, we, addr, data, valid, running, ovf, we8, addr8, ovf8);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_i          = 1'b1;
    load_valid_i     = 1'b0;
    stall_pipeline_i = 1'b0;
    branch_taken_i   = 1'b0;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  // Leave LOAD immediately; afterwards the next step issues RESET_PC.
  task automatic go_run();
    do_reset();
    program_load_i = 1'b0;
    step();  // LOAD -> PRIME
    step();  // PRIME -> RUN, bubble at RESET_PC on the outputs
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    #12;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", we); end
    n_checks++; if (data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", data); end
    n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", addr); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
  endtask

  task automatic test_load_and_prime();
    logic [15:0] d;
    do_reset();
    program_load_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 16'h1111 * 16'(i + 1);
      load_valid_i = 1'b1;
      load_data_i  = d;
      // Final halfword arrives together with the load drop and must still land.
      if (i == 3) program_load_i = 1'b0;
      step();
      n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL load_we[%0d]: got %b expected 1", i, we); end
      n_checks++; if (addr !== 32'(2 * i)) begin n_fail++; $display("FAIL load_addr[%0d]: got %h expected %h", i, addr, 2 * i); end
      n_checks++; if (data !== d) begin n_fail++; $display("FAIL load_data[%0d]: got %h expected %h", i, data, d); end
    end
    load_valid_i = 1'b0;
    step();  // PRIME outputs
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL prime_we: got %b expected 0", we); end
    n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL prime_addr: got %h expected 0", addr); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL prime_valid: got %b expected 0", valid); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL prime_running: got %b expected 0", running); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (addr !== 32'(2 * i)) begin n_fail++; $display("FAIL fetch_addr[%0d]: got %h expected %h", i, addr, 2 * i); end
      n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid[%0d]: got %b expected 1", i, valid); end
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL fetch_running[%0d]: got %b expected 1", i, running); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    program_load_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load_valid_i = 1'b1;
      load_data_i  = 16'hA000 + 16'(i);
      step();
      if (i < 4) begin
        n_checks++; if (we8 !== 1'b1) begin n_fail++; $display("FAIL ovf_we[%0d]: got %b expected 1", i, we8); end
        n_checks++; if (addr8 !== 32'(2 * i)) begin n_fail++; $display("FAIL ovf_addr[%0d]: got %h expected %h", i, addr8, 2 * i); end
        n_checks++; if (ovf8 !== 1'b0) begin n_fail++; $display("FAIL ovf_early[%0d]: got %b expected 0", i, ovf8); end
      end else begin
        n_checks++; if (we8 !== 1'b0) begin n_fail++; $display("FAIL ovf_suppress_we: got %b expected 0", we8); end
        n_checks++; if (addr8 !== 32'h6) begin n_fail++; $display("FAIL ovf_hold_addr: got %h expected 6", addr8); end
        n_checks++; if (ovf8 !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf8); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_big_clear: got %b expected 0", ovf); end
      end
    end
    load_valid_i   = 1'b0;
    program_load_i = 1'b0;
    step();
    step();  // PRIME
    // Fetch wraps modulo 8 bytes: 0,2,4,6,0.
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (addr8 !== 32'((2 * i) % 8)) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, addr8, (2 * i) % 8); end
    end
    n_checks++; if (ovf8 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf8); end
    do_reset();
    n_checks++; if (ovf8 !== 1'b0) begin n_fail++; $display("FAIL ovf_reset_clear: got %b expected 0", ovf8); end
  endtask

  task automatic test_branch();
    go_run();
    step(); step(); step();  // 0,2,4
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0015;
    step();
    branch_taken_i = 1'b0;
    n_checks++; if (addr !== 32'h14) begin n_fail++; $display("FAIL br_addr: got %h expected 14", addr); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL br_bubble: got %b expected 0", valid); end
    step();
    n_checks++; if (addr !== 32'h16) begin n_fail++; $display("FAIL br_next_addr: got %h expected 16", addr); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL br_next_valid: got %b expected 1", valid); end
    step();
    n_checks++; if (addr !== 32'h18) begin n_fail++; $display("FAIL br_seq_addr: got %h expected 18", addr); end
  endtask

  task automatic test_stall();
    go_run();
    for (int i = 0; i < 5; i++) step();  // last fetch at 0x8
    n_checks++; if (addr !== 32'h8) begin n_fail++; $display("FAIL stall_pre_addr: got %h expected 8", addr); end
    stall_pipeline_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (addr !== 32'h8) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected 8", i, addr); end
      n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, valid); end
    end
    stall_pipeline_i = 1'b0;
    step();
    n_checks++; if (addr !== 32'hA) begin n_fail++; $display("FAIL stall_resume: got %h expected a", addr); end
  endtask

  task automatic test_branch_during_stall();
    go_run();
    step(); step();  // 0,2
    stall_pipeline_i = 1'b1;
    branch_taken_i   = 1'b1;
    branch_target_i  = 32'h0000_0040;
    step();
    n_checks++; if (addr !== 32'h40) begin n_fail++; $display("FAIL bs_addr: got %h expected 40", addr); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bs_bubble: got %b expected 0", valid); end
    stall_pipeline_i = 1'b0;
    branch_taken_i   = 1'b0;
    step();
    n_checks++; if (addr !== 32'h42) begin n_fail++; $display("FAIL bs_next: got %h expected 42", addr); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL bs_next_valid: got %b expected 1", valid); end
  endtask

  task automatic test_target_truncation();
    go_run();
    step();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0207;  // 0x207 mod 512 = 7 -> 6
    step();
    branch_taken_i = 1'b0;
    n_checks++; if (addr !== 32'h6) begin n_fail++; $display("FAIL trunc_addr: got %h expected 6", addr); end
    step();
    n_checks++; if (addr !== 32'h8) begin n_fail++; $display("FAIL trunc_next: got %h expected 8", addr); end
  endtask

  task automatic test_return_to_load();
    go_run();
    step(); step(); step();
    program_load_i = 1'b1;
    step();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ret_valid: got %b expected 0", valid); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL ret_running: got %b expected 0", running); end
    load_valid_i = 1'b1;
    load_data_i  = 16'hABCD;
    step();
    load_valid_i = 1'b0;
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL ret_we: got %b expected 1", we); end
    n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL ret_addr: got %h expected 0", addr); end
    n_checks++; if (data !== 16'hABCD) begin n_fail++; $display("FAIL ret_data: got %h expected abcd", data); end
  endtask

  task automatic test_async_reset();
    go_run();
    step(); step(); step();
    #2;
    reset_i = 1'b1;
    #1;  // well before the next rising edge
    n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL arst_addr: got %h expected 0", addr); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", valid); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL arst_running: got %b expected 0", running); end
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL arst_we: got %b expected 0", we); end
    program_load_i = 1'b1;
    load_valid_i   = 1'b1;
    load_data_i    = 16'h5555;
    @(posedge clk);
    #1;
    n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL arst_no_write: got %b expected 0", we); end
    reset_i = 1'b0;
    step();
    load_valid_i = 1'b0;
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL arst_load_we: got %b expected 1", we); end
    n_checks++; if (addr !== 32'h0) begin n_fail++; $display("FAIL arst_load_addr: got %h expected 0", addr); end
    n_checks++; if (data !== 16'h5555) begin n_fail++; $display("FAIL arst_load_data: got %h expected 5555", data); end
  endtask

  initial begin
    test_reset();
    test_load_and_prime();
    test_overflow();
    test_branch();
    test_stall();
    test_branch_during_stall();
    test_target_truncation();
    test_return_to_load();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net in case the flow ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch-control stage directly upstream of the instruction memory stage. After reset it runs a program-load phase that writes externally supplied 16-bit Thumb halfwords into instruction RAM at sequential addresses. It then sequences the program counter for execution, holding on pipeline stalls and redirecting on taken branches. Every output is registered and drives the instruction memory stage's write-enable, address, data and valid inputs.

## Interface
- MEM_BYTES, 512, instruction RAM capacity in bytes; power of two; halfword slots = MEM_BYTES/2
- RESET_PC, 0, byte address of the first fetched instruction; must be even
- clk_i  in  1  single clock; all state updates on the rising edge
- reset_i  in  1  asynchronous, active-high reset
- program_load_i  in  1  held high to stay in or enter the load phase
- load_valid_i  in  1  load_data_i carries a halfword this cycle
- load_data_i  in  HALF_WORD  halfword to write
- stall_pipeline_i  in  stall_pipeline_sig  hold the PC
- branch_taken_i  in  1  redirect the PC this cycle
- branch_target_i  in  WORD  redirect byte address; bit 0 ignored
- program_mem_write_en_o  out  1  RAM write strobe
- instruction_o  out  HALF_WORD  RAM write data
- instruction_addr_o  out  WORD  RAM byte address (write or fetch)
- is_valid_o  out  1  issued fetch is a real instruction
- load_overflow_o  out  1  sticky: a write was attempted beyond capacity
- running_o  out  1  high in RUN

## Operation
- FSM fetch_state_t: LOAD, PRIME, RUN. Reset enters LOAD.
- LOAD:
  - On load_valid_i, register write-enable=1, data=load_data_i, addr=load_ptr. Then load_ptr += 2.
  - With no valid, write-enable=0.
  - When load_ptr == MEM_BYTES, further valids do not write and set load_overflow_o.
  - When program_load_i is low, go to PRIME. A valid in the same cycle is still written (load wins for that cycle).
- PRIME, one cycle:
  - addr=RESET_PC, write-enable=0, is_valid_o=0.
  - Then go to RUN with pc=RESET_PC.
- RUN:
  - Each cycle addr=pc, is_valid_o=1, then pc += 2.
  - Priority order: branch_taken_i, then stall, then increment.
  - Branch: addr={target[31:1],0}, is_valid_o=0 for that cycle (bubble), then pc=target+2.
  - Stall (no branch): addr and is_valid_o hold their previous values.
  - program_load_i high in RUN returns to LOAD with load_ptr=0. In-flight fetch validity drops the next cycle.
- Arithmetic:
  - PC increments wrap modulo MEM_BYTES, so the upper address bits stay 0.
  - Branch targets ≥ MEM_BYTES are truncated modulo MEM_BYTES.
- load_overflow_o clears only on reset.

## Timing
- Every output is registered, so it responds 1 cycle after its input.
- Reset values (asynchronous):
  - program_mem_write_en_o=0, instruction_o=0, instruction_addr_o=0, is_valid_o=0
  - load_overflow_o=0, running_o=0
  - load_ptr=0, pc=RESET_PC
- Load throughput is one halfword per cycle; back-to-back valids give consecutive addresses 0, 2, 4, ….
- Exit from LOAD: program_load_i falls in cycle N, giving PRIME at N+1, then the first valid fetch at RESET_PC at N+2. running_o rises at N+2.
- Branch: branch_taken_i in cycle N gives addr=target with is_valid_o=0 at N+1, then target+2 with valid at N+2 (absent a stall).
- A branch during a stall is taken; it is not deferred.
- Reset mid-load or mid-run aborts immediately. No partial write is emitted after reset deasserts.

## Structure
- HALF_WORD, WORD, stall_pipeline_sig and fetch_state_t live in GENERAL_DEFS. Add fetch_state_t there.
- No sub-module: one FSM plus two counters (load_ptr, pc) in one file.

## Test plan
- Reset, then 4 load valids 0x1111..0x4444, then drop load → writes at addr 0, 2, 4, 6; PRIME at addr 0 with valid 0; then fetch addrs 0, 2, 4 with valid 1.
- MEM_BYTES=8, 5 load valids → 4 writes; 5th suppressed; load_overflow_o=1 and stays 1 until reset.
- RUN with branch_taken_i=1 and target 0x0000_0015 → addr 0x14 with valid 0, then 0x16 with valid 1.
- Stall asserted for 3 cycles at addr 0x8 → addr holds 0x8 for 3 cycles with valid unchanged; resumes at 0xA.
- Branch and stall in the same cycle → branch taken; bubble, then target+2.
- Assert reset_i asynchronously mid-RUN → all outputs at their reset values before the next edge; state LOAD.
